// File: rtl/output_arbiter_if.sv
// AXI-Stream bundle shared by the router stages; the sidebands exist in every
// instance and are simply ignored by stages that have them disabled.
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
);
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport m (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
             input  tready);
  modport s (input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
             output tready);
endinterface

// File: rtl/output_arbiter.sv
// Round-robin, packet-locked merge of CHANNEL_NUMBER AXI-Stream inputs onto a
// single output driven from a one-entry register slice.
module output_arbiter #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEST_WIDTH           = 4,
  parameter int USER_WIDTH           = 4,
  parameter bit STRB_ENABLE          = 1'b1,
  parameter bit KEEP_ENABLE          = 1'b1,
  parameter bit ID_ENABLE            = 1'b1,
  parameter bit DEST_ENABLE          = 1'b1,
  parameter bit USER_ENABLE          = 1'b1,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                            clk,
  input  logic                            rst,
  axis_if.s                               in [CHANNEL_NUMBER],
  axis_if.m                               out,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] grant,
  output logic                            locked
);
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;
  localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LAST_CH = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                          state_r, state_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_r, grant_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] last_grant_r, last_grant_s;
  logic                            locked_r, locked_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] pick_s;
  logic                            pick_found_s;
  logic                            slice_ready_s;
  logic                            accept_s;

  logic [CHANNEL_NUMBER-1:0] valid_s;
  logic [CHANNEL_NUMBER-1:0] ready_s;
  logic [CHANNEL_NUMBER-1:0] last_s;
  logic [DATA_WIDTH-1:0]     data_s [CHANNEL_NUMBER];
  logic [KEEP_WIDTH-1:0]     strb_s [CHANNEL_NUMBER];
  logic [KEEP_WIDTH-1:0]     keep_s [CHANNEL_NUMBER];
  logic [ID_WIDTH-1:0]       id_s   [CHANNEL_NUMBER];
  logic [DEST_WIDTH-1:0]     dest_s [CHANNEL_NUMBER];
  logic [USER_WIDTH-1:0]     user_s [CHANNEL_NUMBER];

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [KEEP_WIDTH-1:0] out_strb_r;
  logic [KEEP_WIDTH-1:0] out_keep_r;
  logic                  out_last_r;
  logic [ID_WIDTH-1:0]   out_id_r;
  logic [DEST_WIDTH-1:0] out_dest_r;
  logic [USER_WIDTH-1:0] out_user_r;

  // Interface arrays only allow constant indices, so flatten them here.
  for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_in
    assign valid_s[g]  = in[g].tvalid;
    assign last_s[g]   = in[g].tlast;
    assign data_s[g]   = in[g].tdata;
    assign strb_s[g]   = in[g].tstrb;
    assign keep_s[g]   = in[g].tkeep;
    assign id_s[g]     = in[g].tid;
    assign dest_s[g]   = in[g].tdest;
    assign user_s[g]   = in[g].tuser;
    assign in[g].tready = ready_s[g];
  end

  assign slice_ready_s = !out_valid_r || out.tready;
  assign accept_s      = (state_r == LOCKED) && valid_s[grant_r] && slice_ready_s;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int idx_v;
    idx_v        = 0;
    pick_s       = '0;
    pick_found_s = 1'b0;
    for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
      idx_v = (int'(last_grant_r) + k) % CHANNEL_NUMBER;
      if (!pick_found_s && valid_s[CHANNEL_NUMBER_WIDTH'(idx_v)]) begin
        pick_found_s = 1'b1;
        pick_s       = CHANNEL_NUMBER_WIDTH'(idx_v);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Only the locked input sees the slice ready; everyone else is held off.
  always_comb begin
    ready_s = '0;
    if (state_r == LOCKED) begin
      ready_s[grant_r] = slice_ready_s;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state logic: arbitrate in IDLE, release on the accepted TLAST beat.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    locked_s     = locked_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_s  = LOCKED;
          grant_s  = pick_s;
          locked_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && last_s[grant_r]) begin
          state_s      = IDLE;
          last_grant_s = grant_r;
          locked_s     = 1'b0;
        end else begin
          state_s      = LOCKED;
        end
      end
      default: begin
        state_s  = IDLE;
        locked_s = 1'b0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= LAST_CH;
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      locked_r     <= locked_s;
    end
  end

  // Output slice: a load wins over a drain, so back-to-back beats keep TVALID high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_strb_r  <= '0;
      out_keep_r  <= '0;
      out_last_r  <= 1'b0;
      out_id_r    <= '0;
      out_dest_r  <= '0;
      out_user_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_s[grant_r];
      out_strb_r  <= STRB_ENABLE ? strb_s[grant_r] : '0;
      out_keep_r  <= KEEP_ENABLE ? keep_s[grant_r] : '0;
      out_last_r  <= last_s[grant_r];
      out_id_r    <= ID_ENABLE   ? id_s[grant_r]   : '0;
      out_dest_r  <= DEST_ENABLE ? dest_s[grant_r] : '0;
      out_user_r  <= USER_ENABLE ? user_s[grant_r] : '0;
    end else if (out.tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out.tvalid = out_valid_r;
  assign out.tdata  = out_data_r;
  assign out.tstrb  = out_strb_r;
  assign out.tkeep  = out_keep_r;
  assign out.tlast  = out_last_r;
  assign out.tid    = out_id_r;
  assign out.tdest  = out_dest_r;
  assign out.tuser  = out_user_r;
  assign grant      = grant_r;
  assign locked     = locked_r;

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Output-side counterpart of the router's input routing/demux stage.
- Merges CHANNEL_NUMBER AXI-Stream inputs (one per router input port, already steered to this output) onto one AXI-Stream output.
- Round-robin arbitration with wormhole locking: a granted input owns the output until its TLAST beat is accepted. The output is driven from a registered slice.

Parameters:
- DATA_WIDTH, 32, TDATA width.
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, 4, sideband widths; present only when TID/TDEST/TUSER are enabled.
- CHANNEL_NUMBER, 5, number of competing inputs.
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), grant index width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in  axis_if.s  [CHANNEL_NUMBER]  competing input streams (TVALID, TREADY, TDATA, TLAST, optional sidebands).
- out  axis_if.m  1  merged output stream.
- grant  output  CHANNEL_NUMBER_WIDTH  index of the currently locked input (registered).
- locked  output  1  high while in LOCKED state.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, locked=0, last_grant=CHANNEL_NUMBER-1.
  - Output register empty: out.TVALID=0, out.TDATA=0, out.TLAST=0, sidebands 0.
  - All in[i].TREADY=0.
- States: IDLE, LOCKED.
- IDLE:
  - All in[i].TREADY=0.
  - If any in[i].TVALID, pick the first asserted index searching from (last_grant+1) mod CHANNEL_NUMBER upward with wrap.
  - Register it into grant; state->LOCKED; locked=1 at next edge.
  - No beat is transferred in the arbitration cycle.
- LOCKED:
  - in[grant].TREADY = !out.TVALID || out.TREADY (register-slice pass-through).
  - All other in[i].TREADY=0.
  - Beat accepted when in[grant].TVALID && in[grant].TREADY: TDATA, TLAST and present sidebands (TSTRB/TKEEP/TID/TDEST/TUSER) are captured into the output register unchanged; out.TVALID=1 next cycle.
  - Accepted beat with TLAST=1: state->IDLE, last_grant<=grant, locked<=0 at the same edge.
  - Granted source deasserting TVALID mid-packet: remain LOCKED, no transfer, other inputs stay blocked.
- Output register:
  - Loads on accepted beat.
  - Clears out.TVALID when out.TREADY && out.TVALID and no new beat is loaded.
  - Simultaneous drain and load: the register holds the new beat, out.TVALID stays 1.
  - Contents are held stable while out.TVALID && !out.TREADY (AXIS rule).
- Latency and throughput:
  - First beat: arbitration cycle, then acceptance cycle, then visible on out one cycle after acceptance.
  - Full throughput (1 beat/cycle) within a packet when out.TREADY=1.
  - One bubble cycle between consecutive packets (re-arbitration).
- Single-beat packet (TLAST on first beat) is legal: LOCKED lasts one acceptance.
- Fairness: an input that just finished has lowest priority next arbitration. With all inputs continuously valid, grants cycle 0,1,2,...,N-1,0.
- The output register may still hold the TLAST beat while IDLE arbitrates the next packet. Ordering is preserved because the next acceptance waits on the register-slice ready.
- Reset mid-packet: immediate return to reset values; the partial packet is dropped, no further beats forwarded.
- Inputs are assumed AXIS-compliant: TVALID is not withdrawn before acceptance. No internal check is made.

Test Plan:
- Reset then in[2] sends 3-beat packet 0xA1,0xA2,0xA3(TLAST), out.TREADY=1 -> grant=2 one cycle after TVALID; out shows A1,A2,A3 on consecutive cycles, TLAST only on A3; locked falls after A3 is accepted.
- All 5 inputs continuously valid with single-beat packets, data=index -> out sequence 0,1,2,3,4,0,1... with exactly one bubble between beats.
- in[1] and in[3] valid while in[1] is mid-packet -> in[3].TREADY=0 until in[1] TLAST is accepted; next grant=3.
- out.TREADY held 0 for 4 cycles mid-packet -> out.TDATA/TLAST stable, in[grant].TREADY=0; resumes with no lost or duplicated beats.
- Granted in[0] drops TVALID for 3 cycles mid-packet while in[4] valid -> in[4] still blocked; packet completes from in[0].
- Assert rst during beat 2 of a 4-beat packet -> out.TVALID=0, locked=0, grant=0 immediately; after release, in[0] has first priority.
